// File: rtl/mac_serial2d_pkg.sv
// Shared types and constants for the 2D multi-4bit-serial MAC operand sequencer.
// Holds the operand/digit widths, the operating-mode encoding, the per-step
// control payload and helpers that map a mode to its digit counts.
package mac_serial2d_pkg;

    localparam int unsigned N_WIDTH    = 4;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned DIGITS     = DATA_WIDTH / N_WIDTH;
    localparam int unsigned SEL_WIDTH  = $clog2(DIGITS);
    // Digit counts and diagonal indices need one bit more than a digit select.
    localparam int unsigned CNT_WIDTH  = SEL_WIDTH + 1;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef enum logic [2:0] {
        MODE_8X8 = 3'b000,
        MODE_8X4 = 3'b001,
        MODE_4X4 = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Control presented to the MAC for one serial step.
    typedef struct packed {
        logic [SEL_WIDTH-1:0] a_sel;
        logic [SEL_WIDTH-1:0] w_sel;
        logic                 sign_ctr;
        logic                 shift_ctr;
        logic                 rst_mult;
    } step_t;

    function automatic logic mode_legal(logic [2:0] mode);
        return (mode == MODE_8X8) || (mode == MODE_8X4) || (mode == MODE_4X4);
    endfunction

    // Returns {m, n}: activation digits and weight digits. Unknown modes fall back to full width.
    function automatic logic [2*CNT_WIDTH-1:0] digits_of(mode_e mode);
        case (mode)
            MODE_8X4: return {CNT_WIDTH'(DIGITS), CNT_WIDTH'(1)};
            MODE_4X4: return {CNT_WIDTH'(1), CNT_WIDTH'(1)};
            default:  return {CNT_WIDTH'(DIGITS), CNT_WIDTH'(DIGITS)};
        endcase
    endfunction

endpackage

// File: rtl/mac_serial2d_seq_if.sv
// Operand/step bus between an upstream source and the serial-MAC sequencer.
// master: operand source (drives mode, in_valid, w_in, a_in; sees everything else).
// slave : sequencer (drives in_ready, held operands, step controls, status).
// Optional perf_ops/perf_busy exist when MAC_SERIAL2D_SEQ_PERF_CNT_EN is defined.
interface mac_serial2d_seq_if;
    import mac_serial2d_pkg::*;

    logic [2:0]            mode;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] w_in;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0] a;
    logic [SEL_WIDTH-1:0]  a_sel;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic                  sign_ctr;
    logic                  shift_ctr;
    logic                  rst_mult;
    logic                  mac_en;
    logic                  op_done;
    logic                  mode_err;

`ifdef MAC_SERIAL2D_SEQ_PERF_CNT_EN
    logic [31:0]           perf_ops;
    logic [31:0]           perf_busy;

    modport master (
        output mode, in_valid, w_in, a_in,
        input  in_ready, w, a, a_sel, w_sel, sign_ctr, shift_ctr, rst_mult,
               mac_en, op_done, mode_err, perf_ops, perf_busy
    );

    modport slave (
        input  mode, in_valid, w_in, a_in,
        output in_ready, w, a, a_sel, w_sel, sign_ctr, shift_ctr, rst_mult,
               mac_en, op_done, mode_err, perf_ops, perf_busy
    );
`else
    modport master (
        output mode, in_valid, w_in, a_in,
        input  in_ready, w, a, a_sel, w_sel, sign_ctr, shift_ctr, rst_mult,
               mac_en, op_done, mode_err
    );

    modport slave (
        input  mode, in_valid, w_in, a_in,
        output in_ready, w, a, a_sel, w_sel, sign_ctr, shift_ctr, rst_mult,
               mac_en, op_done, mode_err
    );
`endif

endinterface

// File: rtl/mac_serial2d_step_gen.sv
// Combinational anti-diagonal step walker for the serial MAC.
// Inputs : i (diagonal), j (weight digit), m (activation digits), n (weight digits).
// Outputs: step controls for (i,j), the following (i,j), and last (final step of the op).
// Order  : i = 0..m+n-2, j = max(0,i-m+1)..min(i,n-1).
module mac_serial2d_step_gen
    import mac_serial2d_pkg::*;
(
    input  cnt_t  i,
    input  cnt_t  j,
    input  cnt_t  m,
    input  cnt_t  n,
    output step_t step,
    output cnt_t  i_nxt,
    output cnt_t  j_nxt,
    output logic  last
);

    // One extra bit so i+2 never wraps.
    localparam int unsigned W = CNT_WIDTH + 1;

    logic [W-1:0] i_w, j_w, m_w, n_w;
    logic [W-1:0] j_lo, j_hi, j_lo_nxt;
    logic         last_j;

    always_comb begin
        i_w = W'(i);
        j_w = W'(j);
        m_w = W'(m);
        n_w = W'(n);

        // Inner-loop bounds for this diagonal and the first j of the next one.
        j_lo     = (i_w + W'(1) > m_w) ? (i_w + W'(1) - m_w) : '0;
        j_hi     = (i_w < n_w - W'(1)) ? i_w : (n_w - W'(1));
        j_lo_nxt = (i_w + W'(2) > m_w) ? (i_w + W'(2) - m_w) : '0;

        last_j = (j_w == j_hi);
        last   = last_j && (i_w == m_w + n_w - W'(2));

        step.a_sel     = SEL_WIDTH'(i - j);
        step.w_sel     = SEL_WIDTH'(j);
        step.sign_ctr  = (j_w == n_w - W'(1));
        step.shift_ctr = (i != '0) && (j_w == j_lo);
        step.rst_mult  = (i == '0);

        i_nxt = last_j ? CNT_WIDTH'(i_w + W'(1)) : i;
        j_nxt = last_j ? CNT_WIDTH'(j_lo_nxt)    : (j + CNT_WIDTH'(1));
    end

endmodule

// File: rtl/mac_serial2d_seq.sv
// Operand sequencer for the 2D multi-4bit-serial MAC.
// Accepts one weight/activation pair per valid/ready handshake and replays it as
// m*n registered steps (a_sel, w_sel, sign_ctr, shift_ctr, rst_mult, mac_en).
// Ports: clk_fast, rst (synchronous, active-high), bus (mac_serial2d_seq_if.slave).
// Optional: MAC_SERIAL2D_SEQ_PERF_CNT_EN adds saturating perf_ops / perf_busy counters.
module mac_serial2d_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N_WIDTH    = 4,
    parameter int unsigned SEL_WIDTH  = 1
) (
    input logic               clk_fast,
    input logic               rst,
    mac_serial2d_seq_if.slave bus
);
    import mac_serial2d_pkg::*;

    localparam int unsigned DIG   = DATA_WIDTH / N_WIDTH;
    localparam int unsigned CNT_W = $clog2(DIG) + 1;

    state_e                state_q, state_d;
    logic                  rdy_en_q, rdy_en_d;
    logic [DATA_WIDTH-1:0] w_q, w_d, a_q, a_d;
    logic [CNT_W-1:0]      m_q, m_d, n_q, n_d;
    logic [CNT_W-1:0]      nxt_i_q, nxt_i_d, nxt_j_q, nxt_j_d;
    step_t                 step_q, step_d;
    logic                  last_q, last_d;
    logic                  mac_en_q, mac_en_d;
    logic                  op_done_q, op_done_d;
    logic                  mode_err_q, mode_err_d;

    logic                  in_ready_c, accept, load, issue;
    cnt_t                  mode_m, mode_n;
    logic [CNT_W-1:0]      ld_i, ld_j, ld_m, ld_n;
    step_t                 gen_step;
    cnt_t                  gen_i_nxt, gen_j_nxt;
    logic                  gen_last;

    assign {mode_m, mode_n} = digits_of(mode_e'(bus.mode));

    // Ready in IDLE and during the final step, held low until the first cycle after reset.
    assign in_ready_c = rdy_en_q && ((state_q == ST_IDLE) || last_q);
    assign accept     = bus.in_valid && in_ready_c;

    // Choose the step to load into the output registers at the next edge.
    always_comb begin
        load  = 1'b0;
        issue = 1'b0;
        case (state_q)
            ST_IDLE: load = accept;
            ST_RUN: begin
                if (last_q) load  = accept;
                else        issue = 1'b1;
            end
            default: ;
        endcase
        ld_i = load ? '0 : nxt_i_q;
        ld_j = load ? '0 : nxt_j_q;
        ld_m = load ? CNT_W'(mode_m) : m_q;
        ld_n = load ? CNT_W'(mode_n) : n_q;
    end

    mac_serial2d_step_gen u_step_gen (
        .i     (cnt_t'(ld_i)),
        .j     (cnt_t'(ld_j)),
        .m     (cnt_t'(ld_m)),
        .n     (cnt_t'(ld_n)),
        .step  (gen_step),
        .i_nxt (gen_i_nxt),
        .j_nxt (gen_j_nxt),
        .last  (gen_last)
    );

    // Next-state and registered outputs.
    always_comb begin
        state_d    = ST_IDLE;
        rdy_en_d   = 1'b1;
        w_d        = w_q;
        a_d        = a_q;
        m_d        = m_q;
        n_d        = n_q;
        nxt_i_d    = nxt_i_q;
        nxt_j_d    = nxt_j_q;
        step_d     = '0;
        last_d     = 1'b0;
        mac_en_d   = 1'b0;
        op_done_d  = (state_q == ST_RUN) && last_q;
        mode_err_d = mode_err_q;

        if (load) begin
            w_d = bus.w_in;
            a_d = bus.a_in;
            if (!mode_legal(bus.mode)) mode_err_d = 1'b1;
        end

        if (load || issue) begin
            state_d  = ST_RUN;
            step_d   = gen_step;
            last_d   = gen_last;
            nxt_i_d  = CNT_W'(gen_i_nxt);
            nxt_j_d  = CNT_W'(gen_j_nxt);
            m_d      = ld_m;
            n_d      = ld_n;
            mac_en_d = 1'b1;
        end
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rdy_en_q   <= 1'b0;
            w_q        <= '0;
            a_q        <= '0;
            m_q        <= '0;
            n_q        <= '0;
            nxt_i_q    <= '0;
            nxt_j_q    <= '0;
            step_q     <= '0;
            last_q     <= 1'b0;
            mac_en_q   <= 1'b0;
            op_done_q  <= 1'b0;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= rdy_en_d;
            w_q        <= w_d;
            a_q        <= a_d;
            m_q        <= m_d;
            n_q        <= n_d;
            nxt_i_q    <= nxt_i_d;
            nxt_j_q    <= nxt_j_d;
            step_q     <= step_d;
            last_q     <= last_d;
            mac_en_q   <= mac_en_d;
            op_done_q  <= op_done_d;
            mode_err_q <= mode_err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.w         = w_q;
    assign bus.a         = a_q;
    assign bus.a_sel     = SEL_WIDTH'(step_q.a_sel);
    assign bus.w_sel     = SEL_WIDTH'(step_q.w_sel);
    assign bus.sign_ctr  = step_q.sign_ctr;
    assign bus.shift_ctr = step_q.shift_ctr;
    assign bus.rst_mult  = step_q.rst_mult;
    assign bus.mac_en    = mac_en_q;
    assign bus.op_done   = op_done_q;
    assign bus.mode_err  = mode_err_q;

`ifdef MAC_SERIAL2D_SEQ_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_ops_d, perf_busy_q, perf_busy_d;

    // Saturating activity counters.
    always_comb begin
        perf_ops_d  = perf_ops_q;
        perf_busy_d = perf_busy_q;
        if (op_done_d && (perf_ops_q != '1))  perf_ops_d  = perf_ops_q + 32'd1;
        if (mac_en_d && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + 32'd1;
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_ops_q  <= perf_ops_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign bus.perf_ops  = perf_ops_q;
    assign bus.perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_mac_serial2d_seq.sv
// Directed self-checking bench for mac_serial2d_seq.
module tb_mac_serial2d_seq;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mac_serial2d_seq_if bus ();

    mac_serial2d_seq dut (
        .clk_fast (clk),
        .rst      (rst),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {a_sel, w_sel, sign_ctr, shift_ctr, rst_mult, mac_en}
    function automatic logic [5:0] obs_step();
        return {bus.a_sel, bus.w_sel, bus.sign_ctr, bus.shift_ctr, bus.rst_mult, bus.mac_en};
    endfunction

    function automatic logic [5:0] st(input logic as, input logic ws, input logic sg,
                                      input logic sh, input logic rm);
        return {as, ws, sg, sh, rm, 1'b1};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] seq88 [4];
        logic [8:0] d_en, d_rm, d_dn;

        seq88[0] = st(0, 0, 0, 0, 1);
        seq88[1] = st(1, 0, 0, 1, 0);
        seq88[2] = st(0, 1, 1, 0, 0);
        seq88[3] = st(1, 1, 1, 1, 0);

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode     = 3'b000;
        bus.w_in     = '0;
        bus.a_in     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_step", 32'(obs_step()), 32'h0);
        check("rst_ready_done_err", 32'({bus.in_ready, bus.op_done, bus.mode_err}), 32'h0);
        check("rst_wa", 32'({bus.w, bus.a}), 32'h0);
        rst = 1'b0;
        #1 check("ready_still_low", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        check("ready_rises", 32'(bus.in_ready), 32'h1);

        // Mode 000, single pair
        bus.mode = 3'b000; bus.w_in = 8'h85; bus.a_in = 8'h3C; bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            check($sformatf("m000_step%0d", k), 32'(obs_step()), 32'(seq88[k]));
            check($sformatf("m000_ready%0d", k), 32'(bus.in_ready), (k == 3) ? 32'h1 : 32'h0);
            check($sformatf("m000_nodone%0d", k), 32'(bus.op_done), 32'h0);
        end
        check("m000_wa", 32'({bus.w, bus.a}), 32'h853C);
        @(negedge clk);
        check("m000_done", 32'({bus.op_done, bus.in_ready}), 32'h3);
        check("m000_idle_step", 32'(obs_step()), 32'h0);
        check("m000_wa_hold", 32'({bus.w, bus.a}), 32'h853C);
        @(negedge clk);
        check("m000_done_pulse", 32'(bus.op_done), 32'h0);

        // Mode 001, single pair
        bus.mode = 3'b001; bus.w_in = 8'h7F; bus.a_in = 8'hA5; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("m001_step0", 32'(obs_step()), 32'(st(0, 0, 1, 0, 1)));
        @(negedge clk);
        check("m001_step1", 32'(obs_step()), 32'(st(1, 0, 1, 1, 0)));
        check("m001_ready_last", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        check("m001_done", 32'({bus.op_done, bus.mac_en}), 32'h2);

        // Mode 111, valid held for three pairs
        bus.mode = 3'b111; bus.w_in = 8'h01; bus.a_in = 8'h11; bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("m111_step%0d", k), 32'(obs_step()), 32'(st(0, 0, 1, 0, 1)));
            check($sformatf("m111_a%0d", k), 32'(bus.a), 32'(8'(17 * (k + 1))));
            check($sformatf("m111_done%0d", k), 32'(bus.op_done), (k > 0) ? 32'h1 : 32'h0);
            check($sformatf("m111_ready%0d", k), 32'(bus.in_ready), 32'h1);
            if (k < 2) bus.a_in = 8'(17 * (k + 2));
            else       bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check("m111_final_done", 32'({bus.op_done, bus.mac_en}), 32'h2);

        // Mode 000, back-to-back pairs
        d_en = 9'b011111111;
        d_rm = 9'b000010001;
        d_dn = 9'b100010000;
        bus.mode = 3'b000; bus.w_in = 8'h12; bus.a_in = 8'h34; bus.in_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("b2b_en_c%0d", c), 32'(bus.mac_en), 32'(d_en[c-1]));
            check($sformatf("b2b_rm_c%0d", c), 32'(bus.rst_mult), 32'(d_rm[c-1]));
            check($sformatf("b2b_dn_c%0d", c), 32'(bus.op_done), 32'(d_dn[c-1]));
            if (c == 1) begin
                bus.w_in = 8'h56; bus.a_in = 8'h78;
            end
            if (c == 4) check("b2b_hold_first", 32'({bus.w, bus.a}), 32'h1234);
            if (c == 5) begin
                check("b2b_second", 32'({bus.w, bus.a}), 32'h5678);
                bus.in_valid = 1'b0;
            end
        end

        // Reset during the second step
        bus.w_in = 8'h9A; bus.a_in = 8'hBC; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("abort_step1", 32'(obs_step()), 32'(seq88[1]));
        rst = 1'b1;
        @(negedge clk);
        check("abort_step", 32'(obs_step()), 32'h0);
        check("abort_nodone", 32'({bus.op_done, bus.in_ready}), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'({obs_step(), bus.op_done, bus.in_ready}), 32'h1);
        bus.w_in = 8'hDE; bus.a_in = 8'hAD; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("restart_step0", 32'(obs_step()), 32'(seq88[0]));
        check("restart_wa", 32'({bus.w, bus.a}), 32'hDEAD);
        repeat (3) @(negedge clk);
        check("restart_nodone_yet", 32'(bus.op_done), 32'h0);
        @(negedge clk);
        check("restart_done", 32'(bus.op_done), 32'h1);

        // Illegal mode, fresh reset so counters start at zero
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("err_clear", 32'(bus.mode_err), 32'h0);
        bus.mode = 3'b010; bus.w_in = 8'hF0; bus.a_in = 8'h0F; bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.mode = 3'b111;
            check($sformatf("ill_step%0d", k), 32'(obs_step()), 32'(seq88[k]));
            check($sformatf("ill_err%0d", k), 32'(bus.mode_err), 32'h1);
        end
        @(negedge clk);
        check("ill_done", 32'({bus.op_done, bus.mode_err}), 32'h3);
`ifdef MAC_SERIAL2D_SEQ_PERF_CNT_EN
        check("perf_ops", bus.perf_ops, 32'd1);
        check("perf_busy", bus.perf_busy, 32'd4);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("err_rst", 32'(bus.mode_err), 32'h0);
`ifdef MAC_SERIAL2D_SEQ_PERF_CNT_EN
        check("perf_rst", 32'(bus.perf_ops | bus.perf_busy), 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
